// File: rtl/rom_cache_pkg.sv
// rtl/rom_cache_pkg.sv - shared types and default widths for the ROM read cache
package rom_cache_pkg;

  localparam int AW_DEF       = 22;
  localparam int IDX_BITS_DEF = 6;
  localparam int CNT_W_DEF    = 16;
  localparam int DATA_W       = 64;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  typedef struct packed {
    logic                               valid;
    logic [AW_DEF-IDX_BITS_DEF-1:0]     tag;
    logic [DATA_W-1:0]                  data;
  } line_t;

endpackage

// File: rtl/rom_cache_ram.sv
// rtl/rom_cache_ram.sv - single-port synchronous line RAM, registered read data
module rom_cache_ram
  import rom_cache_pkg::*;
#(
  parameter int DEPTH_BITS = IDX_BITS_DEF,
  parameter int WIDTH      = $bits(line_t)
) (
  input  logic                  clk,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  // No reset on the array or read register so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/rom_read_cache.sv
// rtl/rom_read_cache.sv - direct-mapped 64-bit ROM read cache in front of a DDR3 read channel
module rom_read_cache
  import rom_cache_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [AW-1:0]    cpu_addr,
  input  logic             cpu_req,
  output logic             cpu_ack,
  output logic [63:0]      cpu_data,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [63:0]      mem_data,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W  = AW - IDX_BITS;
  localparam int LINE_W = 1 + TAG_W + 64;
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t              state;
  logic [IDX_BITS-1:0] flush_idx;
  logic [AW-1:0]       addr_q;
  logic                flush_pend;

  logic [IDX_BITS-1:0] ram_addr;
  logic                ram_we;
  logic [LINE_W-1:0]   ram_wdata;
  logic [LINE_W-1:0]   ram_rdata;

  logic hit;
  logic fill_done;
  logic flushing;

  assign hit       = ram_rdata[LINE_W-1] && (ram_rdata[64 +: TAG_W] == addr_q[AW-1:IDX_BITS]);
  assign fill_done = (state == ST_FILL) && (mem_ack == mem_req);
  assign flushing  = flush_pend | flush;
  assign busy      = (state != ST_IDLE);

  // A fill that overlaps a flush still answers the core but must not leave a valid line behind.
  always_comb begin
    ram_addr  = cpu_addr[IDX_BITS-1:0];
    ram_we    = 1'b0;
    ram_wdata = {1'b1, addr_q[AW-1:IDX_BITS], mem_data};
    case (state)
      ST_FLUSH: begin
        ram_addr  = flush_idx;
        ram_we    = 1'b1;
        ram_wdata = '0;
      end
      ST_FILL: begin
        ram_addr = addr_q[IDX_BITS-1:0];
        ram_we   = fill_done & ~flushing;
      end
      default: ;
    endcase
  end

  rom_cache_ram #(
    .DEPTH_BITS (IDX_BITS),
    .WIDTH      (LINE_W)
  ) u_ram (
    .clk   (clk_sys),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_FLUSH;
      flush_idx  <= '0;
      addr_q     <= '0;
      flush_pend <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_data   <= '0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      // Later assignments clear this again whenever FLUSH is actually entered.
      if (flush) flush_pend <= 1'b1;
      case (state)
        ST_FLUSH: begin
          flush_pend <= 1'b0;
          if (flush) begin
            flush_idx <= '0;
          end else begin
            flush_idx <= flush_idx + 1'b1;
            if (flush_idx == LAST_IDX) state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (flush) begin
            state      <= ST_FLUSH;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req != cpu_ack) begin
            addr_q <= cpu_addr;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            cpu_data <= ram_rdata[63:0];
            cpu_ack  <= ~cpu_ack;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (flushing) begin
              state      <= ST_FLUSH;
              flush_idx  <= '0;
              flush_pend <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            mem_addr <= addr_q;
            mem_req  <= ~mem_req;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_done) begin
            cpu_data <= mem_data;
            cpu_ack  <= ~cpu_ack;
            if (flushing) begin
              state      <= ST_FLUSH;
              flush_idx  <= '0;
              flush_pend <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_cache.sv
// tb/tb_rom_read_cache.sv - randomized self-checking bench for rom_read_cache
module tb_rom_read_cache;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [21:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_ack;
  logic [63:0] cpu_data;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        busy;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic        flush2;
  logic [21:0] cpu_addr2;
  logic        cpu_req2;
  logic        cpu_ack2;
  logic [63:0] cpu_data2;
  logic [21:0] mem_addr2;
  logic        mem_req2;
  logic        mem_ack2;
  logic [63:0] mem_data2;
  logic        busy2;
  logic [1:0]  hit_cnt2;
  logic [1:0]  miss_cnt2;

  int vectors    = 0;
  int miscompares = 0;

  bit          mv [64];
  logic [15:0] mt [64];
  int          m_hits;
  int          m_misses;
  int          mem_reads = 0;
  int          mem_delay = 0;
  int          dly = 0;

  always #5 clk_sys = ~clk_sys;

  rom_read_cache dut (
    .clk_sys (clk_sys), .reset_n (reset_n), .flush (flush),
    .cpu_addr (cpu_addr), .cpu_req (cpu_req), .cpu_ack (cpu_ack), .cpu_data (cpu_data),
    .mem_addr (mem_addr), .mem_req (mem_req), .mem_ack (mem_ack), .mem_data (mem_data),
    .busy (busy), .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
  );

  rom_read_cache #(.AW(22), .IDX_BITS(6), .CNT_W(2)) dut_sat (
    .clk_sys (clk_sys), .reset_n (reset_n), .flush (flush2),
    .cpu_addr (cpu_addr2), .cpu_req (cpu_req2), .cpu_ack (cpu_ack2), .cpu_data (cpu_data2),
    .mem_addr (mem_addr2), .mem_req (mem_req2), .mem_ack (mem_ack2), .mem_data (mem_data2),
    .busy (busy2), .hit_cnt (hit_cnt2), .miss_cnt (miss_cnt2)
  );

  function automatic logic [63:0] rom_word(input logic [21:0] a);
    if (a == 22'h000040) return 64'h1122334455667788;
    return {a, ~a, 20'hABCDE};
  endfunction

  // DDR3 model: answers each toggle after mem_delay cycles
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      dly     = 0;
    end else if (mem_req !== mem_ack) begin
      if (dly >= mem_delay) begin
        mem_data = rom_word(mem_addr);
        mem_ack  = mem_req;
        dly      = 0;
        mem_reads++;
      end else begin
        dly++;
      end
    end
  end

  assign mem_ack2  = mem_req2;
  assign mem_data2 = rom_word(mem_addr2);

  function automatic bit model_hit(input logic [21:0] a);
    return mv[a[5:0]] && (mt[a[5:0]] == a[21:6]);
  endfunction

  task automatic model_access(input logic [21:0] a);
    if (model_hit(a)) m_hits++;
    else begin
      m_misses++;
      mv[a[5:0]] = 1'b1;
      mt[a[5:0]] = a[21:6];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  task automatic wait_ack(output int lat, output bit to);
    lat = 0;
    while (cpu_ack !== cpu_req && lat < 400) begin
      @(posedge clk_sys); #1;
      lat++;
    end
    to = (cpu_ack !== cpu_req);
  endtask

  task automatic wait_idle(output bit to);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(posedge clk_sys); #1;
      n++;
    end
    to = (busy !== 1'b0);
  endtask

  task automatic cpu_read(input logic [21:0] a, output int lat, output int reads, output bit to);
    int r0;
    @(posedge clk_sys); #1;
    r0       = mem_reads;
    cpu_addr = a;
    cpu_req  = ~cpu_req;
    wait_ack(lat, to);
    reads = mem_reads - r0;
  endtask

  task automatic cpu_read2(input logic [21:0] a, output bit to);
    int n = 0;
    @(posedge clk_sys); #1;
    cpu_addr2 = a;
    cpu_req2  = ~cpu_req2;
    while (cpu_ack2 !== cpu_req2 && n < 400) begin
      @(posedge clk_sys); #1;
      n++;
    end
    to = (cpu_ack2 !== cpu_req2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    vectors++; if (cpu_data !== 64'h0) begin miscompares++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data); end
    vectors++; if (mem_addr !== 22'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    vectors++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_cnt, miss_cnt); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", busy); end
  endtask

  task automatic test_flush_then_miss();
    int  early = 0;
    int  lat;
    bit  to;
    @(posedge clk_sys); #1;
    reset_n  = 1'b1;
    mem_delay = 3;
    cpu_addr = 22'h000040;
    cpu_req  = ~cpu_req;
    for (int i = 0; i < 63; i++) begin
      @(posedge clk_sys); #1;
      if (mem_req !== 1'b0) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL flush_blocks_mem_req: got %0d early cycles expected 0", early); end
    wait_ack(lat, to);
    model_access(22'h000040);
    vectors++; if (to) begin miscompares++; $display("FAIL first_miss_ack: got timeout expected ack"); end
    vectors++; if (cpu_data !== 64'h1122334455667788) begin miscompares++; $display("FAIL first_miss_data: got %h expected 1122334455667788", cpu_data); end
    vectors++; if (mem_reads != 1 || mem_req !== 1'b1) begin miscompares++; $display("FAIL first_miss_ddr: got %0d reads mem_req %b expected 1 read mem_req 1", mem_reads, mem_req); end
    vectors++; if (miss_cnt !== 16'(m_misses) || hit_cnt !== 16'(m_hits)) begin miscompares++; $display("FAIL first_miss_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
  endtask

  task automatic test_hit();
    int lat, reads;
    bit to;
    logic prev_mem_req = mem_req;
    cpu_read(22'h000040, lat, reads, to);
    model_access(22'h000040);
    vectors++; if (to || lat != 2) begin miscompares++; $display("FAIL hit_latency: got %0d cycles (timeout %0b) expected 2", lat, to); end
    vectors++; if (cpu_data !== 64'h1122334455667788) begin miscompares++; $display("FAIL hit_data: got %h expected 1122334455667788", cpu_data); end
    vectors++; if (reads != 0 || mem_req !== prev_mem_req) begin miscompares++; $display("FAIL hit_no_ddr: got %0d reads expected 0", reads); end
    vectors++; if (hit_cnt !== 16'(m_hits)) begin miscompares++; $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, m_hits); end
  endtask

  task automatic test_conflict();
    int lat, reads;
    bit to;
    int m0 = m_misses;
    cpu_read(22'h000080, lat, reads, to);
    model_access(22'h000080);
    vectors++; if (to || reads != 1 || cpu_data !== rom_word(22'h000080)) begin miscompares++; $display("FAIL conflict_miss_a: got reads %0d data %h expected 1 read data %h", reads, cpu_data, rom_word(22'h000080)); end
    cpu_read(22'h000040, lat, reads, to);
    model_access(22'h000040);
    vectors++; if (to || reads != 1 || cpu_data !== 64'h1122334455667788) begin miscompares++; $display("FAIL conflict_miss_b: got reads %0d data %h expected 1 read data 1122334455667788", reads, cpu_data); end
    vectors++; if (miss_cnt !== 16'(m0 + 2)) begin miscompares++; $display("FAIL conflict_miss_cnt: got %0d expected %0d", miss_cnt, m0 + 2); end
  endtask

  task automatic test_flush_mid_fill();
    int lat, reads;
    bit to;
    mem_delay = 40;
    @(posedge clk_sys); #1;
    cpu_addr = 22'h000100;
    cpu_req  = ~cpu_req;
    repeat (10) @(posedge clk_sys);
    #1 flush = 1'b1;
    @(posedge clk_sys);
    #1 flush = 1'b0;
    wait_ack(lat, to);
    m_misses++;
    model_invalidate();
    vectors++; if (to || cpu_data !== rom_word(22'h000100)) begin miscompares++; $display("FAIL flush_fill_data: got %h (timeout %0b) expected %h", cpu_data, to, rom_word(22'h000100)); end
    wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL flush_fill_idle: got busy stuck expected idle"); end
    mem_delay = 2;
    cpu_read(22'h000100, lat, reads, to);
    model_access(22'h000100);
    vectors++; if (to || reads != 1) begin miscompares++; $display("FAIL flush_fill_not_written: got %0d reads expected 1", reads); end
    vectors++; if (miss_cnt !== 16'(m_misses)) begin miscompares++; $display("FAIL flush_fill_miss_cnt: got %0d expected %0d", miss_cnt, m_misses); end
  endtask

  task automatic test_flush_with_request();
    int lat, reads;
    bit to;
    int bad = 0;
    logic [21:0] a;
    logic [15:0] tg;
    a  = 22'($urandom_range(0, 22'h3FFFFF));
    tg = mt[a[5:0]] + 16'd1;
    a  = {tg, a[5:0]};
    @(posedge clk_sys); #1;
    cpu_addr = a;
    cpu_req  = ~cpu_req;
    flush    = 1'b1;
    @(posedge clk_sys);
    #1 flush = 1'b0;
    wait_ack(lat, to);
    m_misses++;
    vectors++; if (to || cpu_data !== rom_word(a)) begin miscompares++; $display("FAIL flush_req_data: got %h (timeout %0b) expected %h", cpu_data, to, rom_word(a)); end
    wait_idle(to);
    model_invalidate();
    vectors++; if (to) begin miscompares++; $display("FAIL flush_req_idle: got busy stuck expected idle"); end
    for (int i = 0; i < 64; i++) begin
      logic [21:0] s;
      s = {tg + 16'd1, 6'(i)};
      cpu_read(s, lat, reads, to);
      model_access(s);
      vectors++;
      if (to || reads != 1 || cpu_data !== rom_word(s)) begin
        miscompares++; bad++;
        $display("FAIL flush_sweep_line%0d: got reads %0d data %h expected 1 read data %h", i, reads, cpu_data, rom_word(s));
      end
    end
    vectors++; if (miss_cnt !== 16'(m_misses) || hit_cnt !== 16'(m_hits)) begin miscompares++; $display("FAIL flush_sweep_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
  endtask

  task automatic test_random();
    int lat, reads;
    bit to, eh;
    logic [21:0] a;
    for (int n = 0; n < 150; n++) begin
      a = {16'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
      mem_delay = $urandom_range(0, 5);
      eh = model_hit(a);
      cpu_read(a, lat, reads, to);
      model_access(a);
      vectors++;
      if (to || cpu_data !== rom_word(a) || reads != (eh ? 0 : 1) || (eh && lat != 2)) begin
        miscompares++;
        $display("FAIL rand_read%0d addr %h: got data %h reads %0d lat %0d expected data %h hit %0b", n, a, cpu_data, reads, lat, rom_word(a), eh);
      end
      vectors++;
      if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin
        miscompares++;
        $display("FAIL rand_counters%0d: got %0d/%0d expected %0d/%0d", n, hit_cnt, miss_cnt, m_hits, m_misses);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int lat, reads;
    bit to;
    mem_delay = 50;
    @(posedge clk_sys); #1;
    cpu_addr = 22'h0002A5;
    cpu_req  = ~cpu_req;
    repeat (6) @(posedge clk_sys);
    #1 reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    model_reset();
    vectors++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_fill_toggles: got mem_req %b cpu_ack %b expected 0 0", mem_req, cpu_ack); end
    vectors++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || busy !== 1'b1) begin miscompares++; $display("FAIL reset_fill_state: got %0d/%0d busy %b expected 0/0 busy 1", hit_cnt, miss_cnt, busy); end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    mem_delay = 1;
    wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL reset_fill_idle: got busy stuck expected idle"); end
    cpu_read(22'h0002A5, lat, reads, to);
    model_access(22'h0002A5);
    vectors++; if (to || reads != 1 || cpu_data !== rom_word(22'h0002A5) || miss_cnt !== 16'(m_misses)) begin miscompares++; $display("FAIL reset_fill_reread: got reads %0d data %h miss %0d expected 1 %h %0d", reads, cpu_data, miss_cnt, rom_word(22'h0002A5), m_misses); end
  endtask

  task automatic test_saturation();
    bit to;
    int hits = 0;
    int misses = 0;
    int n = 0;
    while (busy2 !== 1'b0 && n < 400) begin @(posedge clk_sys); #1; n++; end
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL sat_idle: got busy stuck expected idle"); end
    cpu_read2(22'h000123, to);
    misses++;
    for (int k = 1; k <= 5; k++) begin
      cpu_read2(22'h000123, to);
      hits++;
      vectors++;
      if (to || cpu_data2 !== rom_word(22'h000123) || hit_cnt2 !== 2'((hits > 3) ? 3 : hits)) begin
        miscompares++;
        $display("FAIL sat_hit%0d: got hit_cnt %0d data %h expected %0d data %h", k, hit_cnt2, cpu_data2, (hits > 3) ? 3 : hits, rom_word(22'h000123));
      end
    end
    for (int k = 1; k <= 4; k++) begin
      cpu_read2({16'(k + 8), 6'h23}, to);
      misses++;
    end
    vectors++; if (miss_cnt2 !== 2'd3 || hit_cnt2 !== 2'd3) begin miscompares++; $display("FAIL sat_final: got hit %0d miss %0d expected 3 3 (%0d misses issued)", hit_cnt2, miss_cnt2, misses); end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    cpu_addr  = '0;
    cpu_req   = 1'b0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    flush2    = 1'b0;
    cpu_addr2 = '0;
    cpu_req2  = 1'b0;
    test_reset();
    test_flush_then_miss();
    test_hit();
    test_conflict();
    test_flush_mid_fill();
    test_flush_with_request();
    test_random();
    test_reset_mid_fill();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
